// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Brief    : Drains a 1-cycle-latency synchronous FIFO into a valid/ready
//            stream through a 2-entry skid buffer, with word counter and idle.
// Revision : 1.0
// ============================================================================
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic                  idle
);

  localparam logic [2:0] c_depth = 3'(SKID_DEPTH);

  logic [1:0]            r_occ;
  logic                  r_pending;
  logic                  r_head;
  logic                  r_tail;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic [CNT_WIDTH-1:0]  r_words;

  logic                  w_pop;
  logic [2:0]            w_fill;

  assign w_pop = (r_occ != 2'd0) & m_ready;

  // Occupancy after this cycle, counting the in-flight word as already held;
  // this is both the read-admission test and the next occupancy value.
  assign w_fill = {1'b0, r_occ} + {2'b00, r_pending} - {2'b00, w_pop};

  assign fifo_rd_en = rst & en & ~fifo_empty & (w_fill < c_depth);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_occ     <= 2'd0;
      r_pending <= 1'b0;
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_buf[0]  <= '0;
      r_buf[1]  <= '0;
      r_words   <= '0;
    end else begin
      r_pending <= fifo_rd_en;
      r_occ     <= w_fill[1:0];
      if (r_pending) begin
        r_buf[r_tail] <= fifo_data;
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head  <= ~r_head;
        r_words <= r_words + CNT_WIDTH'(1);
      end
    end
  end

  assign m_valid   = (r_occ != 2'd0);
  assign m_data    = r_buf[r_head];
  assign words_out = r_words;
  assign idle      = (r_occ == 2'd0) & ~r_pending & fifo_empty;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst) w_fill <= c_depth);
  a_no_empty_read : assert property (@(posedge clk) !(fifo_rd_en && fifo_empty));

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Brief    : Directed self-checking bench for fifo_stream_reader with a
//            behavioural 1-cycle-latency FIFO model.
// Revision : 1.0
// ============================================================================
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data  = 8'h00;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic [15:0] words_out;
  logic        idle;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int bad_reads = 0;
  bit fifo_flush = 1'b0;

  logic [7:0] wq [$];
  logic [7:0] q  [$];
  logic [7:0] rx [$];

  fifo_stream_reader dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .words_out  (words_out),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // FIFO model: registered data_out, empty updated on the clock edge
  always @(posedge clk) begin
    if (fifo_flush) begin
      q.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en) begin
        rd_cnt++;
        if (fifo_empty) bad_reads++;
        else fifo_data <= q.pop_front();
      end
      while (wq.size() > 0) q.push_back(wq.pop_front());
      fifo_empty <= (q.size() == 0);
    end
    if (rst && m_valid && m_ready) rx.push_back(m_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int base, rd_base, first, last, vcnt, ok;
    logic [7:0] ref_d;
    bit have_ref, prev_stall;

    // ---- reset with a non-empty FIFO ----
    rst = 1'b0; en = 1'b1; m_ready = 1'b1;
    wq.push_back(8'hA5);
    repeat (3) @(negedge clk);
    check("rst_rd_en",   32'(fifo_rd_en), 32'd0);
    check("rst_m_valid", 32'(m_valid),    32'd0);
    check("rst_words",   32'(words_out),  32'd0);
    check("rst_idle",    32'(idle),       32'd0);
    rst = 1'b1;
    #1 check("release_rd_en", 32'(fifo_rd_en), 32'd1);

    // ---- single word, 2-cycle latency ----
    @(negedge clk);
    check("single_rd_once", 32'(fifo_rd_en), 32'd0);
    check("single_t1_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("single_valid", 32'(m_valid), 32'd1);
    check("single_data",  32'(m_data),   32'hA5);
    @(negedge clk);
    check("single_drop",  32'(m_valid),   32'd0);
    check("single_words", 32'(words_out), 32'd1);
    check("single_idle",  32'(idle),      32'd1);
    check("single_reads", 32'(rd_cnt),    32'd1);

    // ---- streaming 16 words at full rate ----
    reset_pulse();
    base = rx.size();
    for (int i = 1; i <= 16; i++) wq.push_back(8'(i));
    first = -1; last = -1; vcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_valid) begin
        vcnt++;
        if (first < 0) first = c;
        last = c;
      end
    end
    check("stream_vcnt", 32'(vcnt), 32'd16);
    check("stream_consecutive", 32'(last - first), 32'd15);
    check("stream_count", 32'(rx.size() - base), 32'd16);
    ok = 1;
    for (int i = 0; i < 16; i++) if (rx[base+i] !== 8'(i + 1)) ok = 0;
    check("stream_order", 32'(ok), 32'd1);
    check("stream_words", 32'(words_out), 32'd16);

    // ---- backpressure ----
    reset_pulse();
    base = rx.size(); rd_base = rd_cnt;
    m_ready = 1'b0;
    for (int i = 1; i <= 16; i++) wq.push_back(8'(i));
    have_ref = 1'b0; ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (m_valid) begin
        if (have_ref && m_data !== ref_d) ok = 0;
        ref_d = m_data; have_ref = 1'b1;
      end
    end
    check("stall_reads", 32'(rd_cnt - rd_base), 32'd2);
    check("stall_valid", 32'(m_valid), 32'd1);
    check("stall_data",  32'(m_data),  32'h01);
    check("stall_stable", 32'(ok), 32'd1);
    ok = 1; prev_stall = 1'b0;
    for (int c = 0; c < 100 && (rx.size() - base) < 16; c++) begin
      @(negedge clk);
      if (prev_stall && (!m_valid || m_data !== ref_d)) ok = 0;
      m_ready = ~m_ready;
      prev_stall = m_valid && !m_ready;
      ref_d = m_data;
    end
    check("toggle_stable", 32'(ok), 32'd1);
    check("toggle_count", 32'(rx.size() - base), 32'd16);
    ok = 1;
    for (int i = 0; i < 16; i++) if (rx[base+i] !== 8'(i + 1)) ok = 0;
    check("toggle_order", 32'(ok), 32'd1);
    @(negedge clk);
    check("toggle_words", 32'(words_out), 32'd16);

    // ---- enable gating ----
    reset_pulse();
    base = rx.size(); rd_base = rd_cnt;
    en = 1'b0; m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) wq.push_back(8'(i));
    ok = 1;
    repeat (8) begin
      @(negedge clk);
      if (m_valid) ok = 0;
    end
    check("en0_reads", 32'(rd_cnt - rd_base), 32'd0);
    check("en0_no_valid", 32'(ok), 32'd1);
    en = 1'b1;
    #1 check("en1_rd_en", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    en = 1'b0;
    #1 check("en_drop_rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (4) @(negedge clk);
    check("en_drop_reads", 32'(rd_cnt - rd_base), 32'd1);
    check("en_drop_count", 32'(rx.size() - base), 32'd1);
    check("en_drop_data",  32'(rx[base]), 32'h01);
    check("en_drop_words", 32'(words_out), 32'd1);

    // ---- reset mid-stream with a read in flight ----
    en = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_streaming", 32'(m_valid), 32'd1);
    rst = 1'b0; fifo_flush = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(m_valid),   32'd0);
    check("mid_rst_words", 32'(words_out), 32'd0);
    rst = 1'b1; fifo_flush = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_dropped", 32'(m_valid),   32'd0);
    check("mid_idle",    32'(idle),      32'd1);
    check("mid_words",   32'(words_out), 32'd0);

    // ---- counter wrap ----
    m_ready = 1'b0;
    wq.push_back(8'h5A);
    for (int c = 0; c < 10 && !m_valid; c++) @(negedge clk);
    check("wrap_valid", 32'(m_valid), 32'd1);
    force dut.r_words = 16'hFFFF;
    #1 check("wrap_preset", 32'(words_out), 32'hFFFF);
    release dut.r_words;
    m_ready = 1'b1;
    @(negedge clk);
    check("wrap_words", 32'(words_out), 32'h0000);
    check("wrap_data",  32'(rx[rx.size()-1]), 32'h5A);

    check("no_empty_reads", 32'(bad_reads), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side controller for the team's 16x8 synchronous FIFO.
- Drains the FIFO through its rd_en / data_out / empty interface, which has 1-cycle registered read latency.
- Re-presents the words as a valid/ready stream with a 2-entry skid buffer, so a downstream consumer sees full 1-word/cycle throughput and may stall freely.
- Also provides a drained-word counter and an idle flag.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and stream data.
- SKID_DEPTH, 2, skid buffer entries; fixed at 2, no other values supported.
- CNT_WIDTH, 16, width of the words_out counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  drain enable; 0 stops new FIFO reads, stream output continues.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO data_out; valid the cycle after a read is issued, held otherwise.
- fifo_rd_en  output  1  FIFO read request.
- m_valid  output  1  stream word available.
- m_data  output  DATA_WIDTH  stream word, head of skid buffer.
- m_ready  input  1  consumer accepts word.
- words_out  output  CNT_WIDTH  count of stream handshakes since reset; wraps.
- idle  output  1  high when no buffered word, no read in flight, and fifo_empty=1.

Behaviour:
- Reset (rst=0 at a rising edge):
  - occupancy=0, pending=0, m_valid=0, m_data=0, words_out=0.
  - fifo_rd_en forced 0 combinationally while rst=0.
  - Buffered and in-flight words are discarded.
  - The system resets the FIFO in the same cycle.
- State:
  - occupancy, 0..2: valid entries in skid buffer.
  - pending, 1 bit: a FIFO read was issued last cycle.
  - 2-entry circular buffer with 1-bit head and tail pointers.
- pop = m_valid & m_ready.
- fifo_rd_en = rst & en & ~fifo_empty & ((occupancy - pop + pending) < 2).
  - Combinational from m_ready, fifo_empty and en.
- Never assert fifo_rd_en while fifo_empty=1. The FIFO mishandles a simultaneous write+read when empty, so this rule is mandatory.
- Pending and capture:
  - pending <= fifo_rd_en every cycle.
  - When pending=1, fifo_data is written at tail and tail increments.
- Occupancy update: occupancy <= occupancy + pending - pop. Simultaneous capture and pop leaves occupancy unchanged.
- Stream output:
  - m_valid = (occupancy != 0).
  - m_data = buffer[head].
  - Head increments on pop.
- Stream protocol:
  - m_data holds stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a pop.
- Latency: fifo_rd_en in cycle t -> word captured at end of t+1 -> m_valid/m_data in t+2. The first word reaches the output 2 cycles after FIFO becomes non-empty, with the reader idle and en=1.
- Throughput: with m_ready held 1, one word per cycle is sustained.
- Overflow: occupancy never exceeds 2. Reaching 3 is a design error; flag it with an assertion in simulation.
- Effect of en=0:
  - Blocks new reads only.
  - An in-flight read still lands.
  - Buffered words still drain.
- words_out increments by 1 on each pop, modulo 2^CNT_WIDTH.
- idle = (occupancy==0) & ~pending & fifo_empty.
- Reset mid-operation, including with pending=1: the in-flight word is dropped and the counter clears. The next cycle behaves as post-reset.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with fifo_empty=0 and m_ready=1 -> fifo_rd_en=0, m_valid=0, words_out=0, idle=0. Release rst -> fifo_rd_en=1 on the first cycle.
2. Single word: FIFO with 0xA5, m_ready=1 -> fifo_rd_en for exactly 1 cycle, m_valid=1 with m_data=0xA5 two cycles later for 1 cycle, words_out=1, idle=1 afterwards.
3. Streaming: FIFO with 0x01..0x10 (16 words), m_ready=1 -> 16 consecutive m_valid cycles with data in order, words_out=16, fifo_rd_en never high while fifo_empty=1.
4. Backpressure: 16 words loaded, m_ready=0 for 10 cycles, then toggling 1/0 -> at most 2 reads issued while stalled, m_data stable during the stall, all 16 words delivered in order with none lost or duplicated.
5. Enable gating: en=0 with a full FIFO -> no fifo_rd_en and m_valid stays 0. Drop en in the same cycle as a read -> that word is still delivered and no further reads are issued.
6. Reset mid-stream: assert rst=0 while occupancy=2 and pending=1 -> next cycle m_valid=0, words_out=0. Counter wrap: force words_out to 0xFFFF, then one pop -> 0x0000.
